// File: rtl/dpram_port_arbiter_if.sv
// Request/response and RAM-side bundle for dpram_port_arbiter.
// The arbiter uses the slave view. Clients and the RAM use the master view.
interface dpram_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_rdata;
  logic [ADDR_WIDTH-1:0]         ram_addr_a, ram_addr_b;
  logic [DATA_WIDTH-1:0]         ram_data_in_a, ram_data_in_b;
  logic                          ram_write_en_a, ram_write_en_b;
  logic                          ram_read_en_a, ram_read_en_b;
  logic [DATA_WIDTH-1:0]         ram_data_out_a, ram_data_out_b;
  logic [CNT_WIDTH-1:0]          conflict_cnt;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  ram_data_out_a, ram_data_out_b,
    output req_ready, rsp_valid, rsp_rdata,
    output ram_addr_a, ram_addr_b, ram_data_in_a, ram_data_in_b,
    output ram_write_en_a, ram_write_en_b, ram_read_en_a, ram_read_en_b,
    output conflict_cnt
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output ram_data_out_a, ram_data_out_b,
    input  req_ready, rsp_valid, rsp_rdata,
    input  ram_addr_a, ram_addr_b, ram_data_in_a, ram_data_in_b,
    input  ram_write_en_a, ram_write_en_b, ram_read_en_a, ram_read_en_b,
    input  conflict_cnt
  );
endinterface

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter that maps up to two requesters per cycle onto the two
// ports of a sync dual-port RAM. It resolves same-address hazards and routes read data back.
module dpram_port_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dpram_port_arbiter_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IW-1:0] id_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic id_t next_id(input id_t i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  id_t                           rr_ptr;
  logic                          gnt_a_p0, gnt_b_p0, defer_p0;
  id_t                           id_a_p0, id_b_p0;
  logic [NUM_REQ-1:0]            ready_p0;
  logic                          vld_a_p1, vld_b_p1;
  id_t                           id_a_p1, id_b_p1;
  logic [NUM_REQ-1:0]            vld_rsp_p1;
  logic [NUM_REQ*DATA_WIDTH-1:0] rdata_hold_p1, rsp_rdata_p1;
  logic [CNT_WIDTH-1:0]          cnt;

  // ---- stage p0: combinational grant scan and RAM drive ----
  always_comb begin
    int idx;
    idx      = 0;
    gnt_a_p0 = 1'b0;
    gnt_b_p0 = 1'b0;
    defer_p0 = 1'b0;
    id_a_p0  = '0;
    id_b_p0  = '0;
    ready_p0 = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!reset && bus.req_valid[idx]) begin
        if (!gnt_a_p0) begin
          gnt_a_p0 = 1'b1;
          id_a_p0  = id_t'(idx);
        end else if (!gnt_b_p0) begin
          // A write on either side to port A's address would collide in the RAM
          if ((bus.req_addr[idx*ADDR_WIDTH +: ADDR_WIDTH] ==
               bus.req_addr[int'(id_a_p0)*ADDR_WIDTH +: ADDR_WIDTH]) &&
              (bus.req_write[idx] || bus.req_write[id_a_p0])) begin
            defer_p0 = 1'b1;
          end else begin
            gnt_b_p0 = 1'b1;
            id_b_p0  = id_t'(idx);
          end
        end
      end
    end
    if (gnt_a_p0) ready_p0[id_a_p0] = 1'b1;
    if (gnt_b_p0) ready_p0[id_b_p0] = 1'b1;
  end

  always_comb begin
    bus.ram_addr_a     = '0;
    bus.ram_data_in_a  = '0;
    bus.ram_write_en_a = 1'b0;
    bus.ram_read_en_a  = 1'b0;
    bus.ram_addr_b     = '0;
    bus.ram_data_in_b  = '0;
    bus.ram_write_en_b = 1'b0;
    bus.ram_read_en_b  = 1'b0;
    if (gnt_a_p0) begin
      bus.ram_addr_a     = bus.req_addr[int'(id_a_p0)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.ram_data_in_a  = bus.req_wdata[int'(id_a_p0)*DATA_WIDTH +: DATA_WIDTH];
      bus.ram_write_en_a = bus.req_write[id_a_p0];
      bus.ram_read_en_a  = ~bus.req_write[id_a_p0];
    end
    if (gnt_b_p0) begin
      bus.ram_addr_b     = bus.req_addr[int'(id_b_p0)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.ram_data_in_b  = bus.req_wdata[int'(id_b_p0)*DATA_WIDTH +: DATA_WIDTH];
      bus.ram_write_en_b = bus.req_write[id_b_p0];
      bus.ram_read_en_b  = ~bus.req_write[id_b_p0];
    end
  end

  assign bus.req_ready = ready_p0;

  // ---- stage p0 -> p1: pointer, pending reads, deferral counter ----
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      vld_a_p1   <= 1'b0;
      vld_b_p1   <= 1'b0;
      vld_rsp_p1 <= '0;
      cnt        <= '0;
    end else begin
      if (gnt_b_p0)      rr_ptr <= next_id(id_b_p0);
      else if (gnt_a_p0) rr_ptr <= next_id(id_a_p0);
      vld_a_p1   <= gnt_a_p0 & ~bus.req_write[id_a_p0];
      vld_b_p1   <= gnt_b_p0 & ~bus.req_write[id_b_p0];
      vld_rsp_p1 <= ready_p0 & ~bus.req_write;
      if (defer_p0) cnt <= sat_inc(cnt);
    end
  end

  always_ff @(posedge clk) begin
    id_a_p1       <= id_a_p0;
    id_b_p1       <= id_b_p0;
    rdata_hold_p1 <= rsp_rdata_p1;
  end

  // ---- stage p1: RAM data arrives now; steer it to the issuing requester ----
  always_comb begin
    rsp_rdata_p1 = rdata_hold_p1;
    if (vld_a_p1 && !reset)
      rsp_rdata_p1[int'(id_a_p1)*DATA_WIDTH +: DATA_WIDTH] = bus.ram_data_out_a;
    if (vld_b_p1 && !reset)
      rsp_rdata_p1[int'(id_b_p1)*DATA_WIDTH +: DATA_WIDTH] = bus.ram_data_out_b;
  end

  assign bus.rsp_valid    = vld_rsp_p1 & {NUM_REQ{~reset}};
  assign bus.rsp_rdata    = rsp_rdata_p1;
  assign bus.conflict_cnt = cnt;
endmodule
